// File: rtl/frame_pingpong_ram.sv
// Ping-pong sample buffer: two 2^ADDR_W-word banks, sequential fill from the ADC stream,
// frame readout in natural or bit-reversed order with a registered RAM output stage.
module frame_pingpong_ram #(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              overrun,
  output logic              frame_ready,
  input  logic              rd_start,
  input  logic              rd_bitrev,
  output logic              rd_busy,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_index,
  output logic              rd_last
);

  localparam int unsigned N = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  logic [DATA_W-1:0] mem [0:2*N-1];

  rd_state_t         state;
  logic              alive;
  logic              wbank;
  logic              rbank;
  logic [1:0]        full;
  logic [1:0]        full_next;
  logic [ADDR_W-1:0] wr_ptr;
  logic              bitrev_q;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] addr_q;
  logic              issue_q;
  logic              issue_last_q;
  logic              wr_fire;
  logic              wr_wrap;
  logic              rd_free;

  function automatic logic [ADDR_W-1:0] reverse_bits(input logic [ADDR_W-1:0] v);
    logic [ADDR_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < ADDR_W; i++) begin
      r[i] = v[ADDR_W-1-i];
    end
    return r;
  endfunction

  // alive keeps wr_ready low through the reset cycles themselves
  assign wr_ready    = alive && !full[wbank];
  assign frame_ready = full[rbank];
  assign rd_busy     = (state != IDLE);

  assign wr_fire = wr_valid && wr_ready;
  assign wr_wrap = wr_fire && (wr_ptr == '1);
  assign rd_free = (state == DRAIN) && rd_last;
  assign rd_addr = bitrev_q ? reverse_bits(cnt) : cnt;

  // A frame completing and a bank being freed on the same edge both take effect
  always_comb begin
    full_next = full;
    if (rd_free) full_next[rbank] = 1'b0;
    if (wr_wrap) full_next[wbank] = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (reset && wr_fire) begin
      mem[{wbank, wr_ptr}] <= wr_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (!reset) begin
      alive        <= 1'b0;
      wbank        <= 1'b0;
      rbank        <= 1'b0;
      full         <= '0;
      wr_ptr       <= '0;
      overrun      <= 1'b0;
      state        <= IDLE;
      bitrev_q     <= 1'b0;
      cnt          <= '0;
      addr_q       <= '0;
      issue_q      <= 1'b0;
      issue_last_q <= 1'b0;
      rd_valid     <= 1'b0;
      rd_last      <= 1'b0;
      rd_data      <= '0;
      rd_index     <= '0;
    end else begin
      alive <= 1'b1;
      full  <= full_next;

      if (wr_valid && !wr_ready) overrun <= 1'b1;
      if (wr_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (wr_ptr == '1) wbank <= ~wbank;
      end

      // Address register feeds the RAM; RAM output is the rd_data register
      rd_valid <= issue_q;
      rd_last  <= issue_last_q;
      if (issue_q) begin
        rd_data  <= mem[{rbank, addr_q}];
        rd_index <= addr_q;
      end
      issue_q      <= 1'b0;
      issue_last_q <= 1'b0;

      case (state)
        IDLE: begin
          if (rd_start && frame_ready) begin
            bitrev_q <= rd_bitrev;
            cnt      <= '0;
            state    <= READ;
          end
        end
        READ: begin
          addr_q       <= rd_addr;
          issue_q      <= 1'b1;
          issue_last_q <= (cnt == '1);
          cnt          <= cnt + 1'b1;
          if (cnt == '1) state <= DRAIN;
        end
        DRAIN: begin
          // stay until the final word has been presented, then release the bank
          if (rd_last) begin
            rbank <= ~rbank;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_pingpong_ram.sv
// Directed bench for frame_pingpong_ram with N=8: reset, natural/bit-reversed reads,
// overrun, streaming at half input rate, and reset during a read.
module tb_frame_pingpong_ram;

  localparam int unsigned DATA_W = 18;
  localparam int unsigned ADDR_W = 3;

  logic              Clk;
  logic              reset;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              overrun;
  logic              frame_ready;
  logic              rd_start;
  logic              rd_bitrev;
  logic              rd_busy;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] rd_index;
  logic              rd_last;

  int checks = 0;
  int errors = 0;
  int tab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  frame_pingpong_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .Clk(Clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .overrun(overrun), .frame_ready(frame_ready),
    .rd_start(rd_start), .rd_bitrev(rd_bitrev), .rd_busy(rd_busy),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_index(rd_index), .rd_last(rd_last)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic write_seq(input int first, input int count);
    for (int i = 0; i < count; i++) begin
      wr_valid = 1'b1;
      wr_data  = DATA_W'(first + i);
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic read_frame(input bit br, input int base, input string tag);
    int w;
    int idx;
    w = 0;
    while (!frame_ready && w < 100) begin
      tick();
      w++;
    end
    check({tag, "_frame_ready"}, 32'(frame_ready), 1);
    rd_start  = 1'b1;
    rd_bitrev = br;
    tick();
    rd_start  = 1'b0;
    rd_bitrev = 1'b0;
    check({tag, "_busy"}, 32'(rd_busy), 1);
    check({tag, "_lat0"}, 32'(rd_valid), 0);
    tick();
    check({tag, "_lat1"}, 32'(rd_valid), 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      idx = br ? tab[i] : i;
      check({tag, "_valid"}, 32'(rd_valid), 1);
      check({tag, "_data"}, 32'(rd_data), 32'(base + idx));
      check({tag, "_index"}, 32'(rd_index), 32'(idx));
      check({tag, "_last"}, 32'(rd_last), (i == 7) ? 1 : 0);
      tick();
    end
    check({tag, "_end_valid"}, 32'(rd_valid), 0);
    check({tag, "_end_busy"}, 32'(rd_busy), 0);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    repeat (cycles) tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int low_seen;
    reset     = 1'b1;
    wr_valid  = 1'b0;
    wr_data   = '0;
    rd_start  = 1'b0;
    rd_bitrev = 1'b0;

    // 1: reset state
    reset = 1'b0;
    tick();
    tick();
    check("rst_wr_ready", 32'(wr_ready), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_frame_ready", 32'(frame_ready), 0);
    check("rst_busy", 32'(rd_busy), 0);
    check("rst_valid", 32'(rd_valid), 0);
    check("rst_last", 32'(rd_last), 0);
    check("rst_data", 32'(rd_data), 0);
    check("rst_index", 32'(rd_index), 0);
    reset = 1'b1;
    tick();
    check("rel_wr_ready", 32'(wr_ready), 1);

    // 2: natural order
    write_seq(1, 8);
    check("nat_frame_ready", 32'(frame_ready), 1);
    check("nat_wr_ready", 32'(wr_ready), 1);
    read_frame(1'b0, 1, "nat");

    // 3: bit-reversed order
    write_seq(1, 8);
    read_frame(1'b1, 1, "rev");

    // 4: overrun with both banks full
    write_seq(1, 16);
    check("ovr_frame_ready", 32'(frame_ready), 1);
    check("ovr_wr_ready", 32'(wr_ready), 0);
    check("ovr_before", 32'(overrun), 0);
    write_seq(99, 1);
    check("ovr_sticky", 32'(overrun), 1);
    read_frame(1'b0, 1, "ovr_f0");
    read_frame(1'b0, 9, "ovr_f1");
    check("ovr_wr_ready_after", 32'(wr_ready), 1);
    check("ovr_still_set", 32'(overrun), 1);
    check("ovr_no_frame", 32'(frame_ready), 0);
    do_reset(2);
    check("ovr_cleared", 32'(overrun), 0);

    // 5: streaming, one sample every other cycle, reads started on frame_ready
    low_seen = 0;
    fork
      begin
        for (int v = 1; v <= 24; v++) begin
          if (!wr_ready) low_seen++;
          wr_valid = 1'b1;
          wr_data  = DATA_W'(v);
          tick();
          wr_valid = 1'b0;
          if (!wr_ready) low_seen++;
          tick();
        end
      end
      begin
        read_frame(1'b0, 1, "str_f0");
        read_frame(1'b0, 9, "str_f1");
        read_frame(1'b0, 17, "str_f2");
      end
    join
    check("str_wr_ready_low", 32'(low_seen), 0);
    check("str_overrun", 32'(overrun), 0);

    // 6: reset during a read
    write_seq(1, 8);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    repeat (5) tick();
    check("mid_valid4", 32'(rd_valid), 1);
    check("mid_data4", 32'(rd_data), 4);
    reset = 1'b0;
    tick();
    check("mid_valid_after_rst", 32'(rd_valid), 0);
    check("mid_busy_after_rst", 32'(rd_busy), 0);
    reset = 1'b1;
    tick();
    check("mid_frame_ready", 32'(frame_ready), 0);
    check("mid_wr_ready", 32'(wr_ready), 1);
    low_seen = 0;
    repeat (4) begin
      if (rd_valid) low_seen++;
      tick();
    end
    check("mid_no_stray_valid", 32'(low_seen), 0);
    write_seq(11, 8);
    read_frame(1'b1, 11, "mid_new");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
